// File: rtl/dct_pkg.sv
// Shared constants for the DCT zigzag reorder buffer: widths, the JPEG zigzag
// source-address table and the reader state encoding.
package dct_pkg;

  localparam int DW  = 12;
  localparam int BLK = 64;

  // Source (row-major) address for each zigzag output index.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic {
    RD_IDLE,
    RD_RUN
  } rd_state_e;

endpackage

// File: rtl/dct_pp_ram.sv
// Two-bank ping-pong coefficient store: simple dual-port RAM with one write
// port and one registered, enabled read port so it maps onto block RAM.
module dct_pp_ram
  import dct_pkg::*;
#(
  parameter int RAM_DW = DW,
  parameter int AW     = $clog2(2 * BLK)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [RAM_DW-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [RAM_DW-1:0] rd_data
);

  logic [RAM_DW-1:0] mem [2**AW];

  // No reset on the array or read register; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/dct_zigzag_buf.sv
// Captures row-major 8x8 DCT blocks into a ping-pong buffer and re-emits each
// block in JPEG zigzag order with a stallable registered output.
module dct_zigzag_buf #(
  parameter int DW  = dct_pkg::DW,
  parameter int BLK = dct_pkg::BLK
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          rdy_in,
  input  logic [DW-1:0] dct_in,
  input  logic          out_en,
  output logic [DW-1:0] zz_out,
  output logic          zz_valid,
  output logic          zz_sof,
  output logic          zz_eob,
  output logic          ovf
);

  import dct_pkg::*;

  localparam int AW = $clog2(BLK);
  localparam logic [AW-1:0] LAST_IDX = AW'(BLK - 1);

  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic [1:0]    bank_full_q, bank_full_d;
  logic          ovf_q, ovf_d;

  rd_state_e     rd_state_q, rd_state_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;

  logic          pipe_valid_q, pipe_valid_d;
  logic          pipe_sof_q, pipe_sof_d;
  logic          pipe_eob_q, pipe_eob_d;

  logic [DW-1:0] zz_out_q, zz_out_d;
  logic          zz_valid_q, zz_valid_d;
  logic          zz_sof_q, zz_sof_d;
  logic          zz_eob_q, zz_eob_d;

  logic          wr_accept;
  logic          wr_last;
  logic          out_move;
  logic          rd_issue;
  logic          rd_last;
  logic [DW-1:0] ram_rd_data;

  assign wr_accept = rdy_in && !bank_full_q[wr_bank_q];
  assign wr_last   = wr_accept && (wr_cnt_q == LAST_IDX);
  assign out_move  = !zz_valid_q || out_en;
  // Index 0 is issued on the IDLE cycle that first sees a full bank.
  assign rd_issue  = out_move && ((rd_state_q == RD_RUN) || bank_full_q[rd_bank_q]);
  assign rd_last   = rd_issue && (rd_state_q == RD_RUN) && (rd_idx_q == LAST_IDX);

  dct_pp_ram #(
    .RAM_DW (DW),
    .AW     (AW + 1)
  ) u_ram (
    .clk     (CLK),
    .wr_en   (wr_accept),
    .wr_addr ({wr_bank_q, wr_cnt_q}),
    .wr_data (dct_in),
    .rd_en   (rd_issue),
    .rd_addr ({rd_bank_q, ZZ[rd_idx_q]}),
    .rd_data (ram_rd_data)
  );

  always_comb begin
    wr_cnt_d     = wr_cnt_q;
    wr_bank_d    = wr_bank_q;
    bank_full_d  = bank_full_q;
    ovf_d        = ovf_q;
    rd_state_d   = rd_state_q;
    rd_bank_d    = rd_bank_q;
    rd_idx_d     = rd_idx_q;
    pipe_valid_d = pipe_valid_q;
    pipe_sof_d   = pipe_sof_q;
    pipe_eob_d   = pipe_eob_q;
    zz_out_d     = zz_out_q;
    zz_valid_d   = zz_valid_q;
    zz_sof_d     = zz_sof_q;
    zz_eob_d     = zz_eob_q;

    if (wr_accept) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_last) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
      end
    end else if (rdy_in) begin
      ovf_d = 1'b1;
    end

    case (rd_state_q)
      RD_IDLE: begin
        if (rd_issue) begin
          rd_state_d = RD_RUN;
          rd_idx_d   = rd_idx_q + 1'b1;
        end
      end
      RD_RUN: begin
        if (rd_last) begin
          bank_full_d[rd_bank_q] = 1'b0;
          rd_bank_d              = ~rd_bank_q;
          rd_idx_d               = '0;
          // Continue straight into the other bank when it is already waiting.
          rd_state_d             = bank_full_q[~rd_bank_q] ? RD_RUN : RD_IDLE;
        end else if (rd_issue) begin
          rd_idx_d = rd_idx_q + 1'b1;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase

    if (out_move) begin
      pipe_valid_d = rd_issue;
      pipe_sof_d   = rd_issue && (rd_idx_q == '0);
      pipe_eob_d   = rd_last;
      zz_valid_d   = pipe_valid_q;
      zz_sof_d     = pipe_sof_q;
      zz_eob_d     = pipe_eob_q;
      if (pipe_valid_q) begin
        zz_out_d = ram_rd_data;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_cnt_q     <= '0;
      wr_bank_q    <= 1'b0;
      bank_full_q  <= 2'b00;
      ovf_q        <= 1'b0;
      rd_state_q   <= RD_IDLE;
      rd_bank_q    <= 1'b0;
      rd_idx_q     <= '0;
      pipe_valid_q <= 1'b0;
      pipe_sof_q   <= 1'b0;
      pipe_eob_q   <= 1'b0;
      zz_out_q     <= '0;
      zz_valid_q   <= 1'b0;
      zz_sof_q     <= 1'b0;
      zz_eob_q     <= 1'b0;
    end else begin
      wr_cnt_q     <= wr_cnt_d;
      wr_bank_q    <= wr_bank_d;
      bank_full_q  <= bank_full_d;
      ovf_q        <= ovf_d;
      rd_state_q   <= rd_state_d;
      rd_bank_q    <= rd_bank_d;
      rd_idx_q     <= rd_idx_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_sof_q   <= pipe_sof_d;
      pipe_eob_q   <= pipe_eob_d;
      zz_out_q     <= zz_out_d;
      zz_valid_q   <= zz_valid_d;
      zz_sof_q     <= zz_sof_d;
      zz_eob_q     <= zz_eob_d;
    end
  end

  assign zz_out   = zz_out_q;
  assign zz_valid = zz_valid_q;
  assign zz_sof   = zz_sof_q;
  assign zz_eob   = zz_eob_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_dct_zigzag_buf.sv
// Self-checking bench for dct_zigzag_buf: expected streams come from a
// diagonal-walk zigzag model applied to the blocks the bench feeds in.
module tb_dct_zigzag_buf;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        rdy_in = 1'b0;
  logic [11:0] dct_in = '0;
  logic        out_en = 1'b1;
  logic [11:0] zz_out;
  logic        zz_valid;
  logic        zz_sof;
  logic        zz_eob;
  logic        ovf;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int zz_tab [64];

  typedef struct {
    logic [11:0] d;
    logic        sof;
    logic        eob;
    int          cyc;
  } obs_t;

  obs_t        got [$];
  logic [11:0] exp_q [$];

  dct_zigzag_buf dut (
    .CLK      (CLK),
    .RST      (RST),
    .rdy_in   (rdy_in),
    .dct_in   (dct_in),
    .out_en   (out_en),
    .zz_out   (zz_out),
    .zz_valid (zz_valid),
    .zz_sof   (zz_sof),
    .zz_eob   (zz_eob),
    .ovf      (ovf)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // A coefficient is consumed on the next rising edge when valid and out_en are both high.
  always @(negedge CLK) begin
    if (zz_valid === 1'b1 && out_en === 1'b1) begin
      got.push_back('{d: zz_out, sof: zz_sof, eob: zz_eob, cyc: cyc});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  task automatic build_zigzag();
    int n = 0;
    for (int s = 0; s <= 14; s++) begin
      for (int k = 0; k < 8; k++) begin
        int r = (s % 2 == 1) ? k : 7 - k;
        int c = s - r;
        if (c >= 0 && c < 8) begin
          zz_tab[n] = r * 8 + c;
          n++;
        end
      end
    end
  endtask

  task automatic push_expected(input logic [11:0] blk [64]);
    for (int i = 0; i < 64; i++) exp_q.push_back(blk[zz_tab[i]]);
  endtask

  task automatic drive_coef(input logic [11:0] v);
    @(posedge CLK);
    #1;
    rdy_in = 1'b1;
    dct_in = v;
  endtask

  task automatic stop_in();
    @(posedge CLK);
    #1;
    rdy_in = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    rdy_in = 1'b0;
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    got.delete();
    exp_q.delete();
  endtask

  task automatic wait_outputs(input int n);
    int budget = 0;
    while (got.size() < n && budget < 3000) begin
      @(posedge CLK);
      budget++;
    end
    repeat (10) @(posedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    rdy_in = 1'b0;
    out_en = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      checks++;
      if ({zz_out, zz_valid, zz_sof, zz_eob, ovf} !== 16'h0) begin
        failures++;
        $display("FAIL reset_outputs got=%h expected=0000", {zz_out, zz_valid, zz_sof, zz_eob, ovf});
      end
    end
    @(posedge CLK);
    #1;
    RST = 1'b1;
    got.delete();
    exp_q.delete();
  endtask

  task automatic test_single_block();
    logic [11:0] blk [64];
    do_reset();
    out_en = 1'b1;
    for (int i = 0; i < 64; i++) blk[i] = 12'(i);
    push_expected(blk);
    for (int i = 0; i < 64; i++) drive_coef(blk[i]);
    stop_in();
    checks++;
    if (zz_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_e0 zz_valid got=%b expected=0", zz_valid);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (zz_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_e1 zz_valid got=%b expected=0", zz_valid);
    end
    @(posedge CLK);
    #1;
    checks++;
    if ({zz_valid, zz_sof, zz_out} !== {1'b1, 1'b1, 12'h000}) begin
      failures++;
      $display("FAIL latency_e2 valid/sof/out got=%b/%b/%h expected=1/1/000", zz_valid, zz_sof, zz_out);
    end
    wait_outputs(64);
    checks++;
    if (got.size() != 64) begin
      failures++;
      $display("FAIL single_count got=%0d expected=64", got.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      logic es = (i % 64 == 0);
      logic ee = (i % 64 == 63);
      checks++;
      if ({got[i].d, got[i].sof, got[i].eob} !== {exp_q[i], es, ee}) begin
        failures++;
        $display("FAIL single_seq[%0d] got=%h/%b/%b expected=%h/%b/%b", i, got[i].d, got[i].sof, got[i].eob, exp_q[i], es, ee);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] blk [64];
    int gaps = 0;
    do_reset();
    out_en = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 64; i++) blk[i] = 12'(b * 100 + i);
      push_expected(blk);
      for (int i = 0; i < 64; i++) drive_coef(blk[i]);
    end
    stop_in();
    wait_outputs(128);
    checks++;
    if (got.size() != 128) begin
      failures++;
      $display("FAIL b2b_count got=%0d expected=128", got.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      logic es = (i % 64 == 0);
      logic ee = (i % 64 == 63);
      checks++;
      if ({got[i].d, got[i].sof, got[i].eob} !== {exp_q[i], es, ee}) begin
        failures++;
        $display("FAIL b2b_seq[%0d] got=%h/%b/%b expected=%h/%b/%b", i, got[i].d, got[i].sof, got[i].eob, exp_q[i], es, ee);
      end
    end
    for (int i = 1; i < got.size(); i++) begin
      if (got[i].cyc != got[i-1].cyc + 1) gaps++;
    end
    checks++;
    if (gaps != 0) begin
      failures++;
      $display("FAIL b2b_bubbles got=%0d expected=0", gaps);
    end
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ovf got=%b expected=0", ovf);
    end
  endtask

  task automatic test_stall();
    logic [11:0] blk [64];
    bit found = 0;
    do_reset();
    out_en = 1'b1;
    for (int i = 0; i < 64; i++) blk[i] = 12'(i);
    push_expected(blk);
    for (int i = 0; i < 64; i++) drive_coef(blk[i]);
    stop_in();
    for (int t = 0; t < 200 && !found; t++) begin
      if (zz_valid === 1'b1 && zz_out === 12'd32) found = 1;
      else begin
        @(posedge CLK);
        #1;
      end
    end
    out_en = 1'b0;
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL stall_reach_idx10 got=not_seen expected=032");
    end
    for (int s = 0; s < 5; s++) begin
      @(negedge CLK);
      checks++;
      if ({zz_valid, zz_out} !== {1'b1, 12'd32}) begin
        failures++;
        $display("FAIL stall_hold[%0d] got=%b/%h expected=1/020", s, zz_valid, zz_out);
      end
    end
    @(posedge CLK);
    #1;
    out_en = 1'b1;
    wait_outputs(64);
    checks++;
    if (got.size() != 64) begin
      failures++;
      $display("FAIL stall_count got=%0d expected=64", got.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i].d !== exp_q[i]) begin
        failures++;
        $display("FAIL stall_seq[%0d] got=%h expected=%h", i, got[i].d, exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [11:0] blk [64];
    do_reset();
    out_en = 1'b0;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 64; i++) blk[i] = 12'($urandom);
      if (b < 2) push_expected(blk);
      for (int i = 0; i < 64; i++) begin
        drive_coef(blk[i]);
        if (b == 2 && i == 0) begin
          checks++;
          if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_before_block3 got=%b expected=0", ovf);
          end
        end
        if (b == 2 && i == 1) begin
          checks++;
          if (ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_first_drop got=%b expected=1", ovf);
          end
        end
      end
    end
    stop_in();
    repeat (5) @(posedge CLK);
    #1;
    checks++;
    if (got.size() != 0) begin
      failures++;
      $display("FAIL ovf_stalled_consumed got=%0d expected=0", got.size());
    end
    out_en = 1'b1;
    wait_outputs(128);
    checks++;
    if (got.size() != 128) begin
      failures++;
      $display("FAIL ovf_count got=%0d expected=128", got.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      logic es = (i % 64 == 0);
      logic ee = (i % 64 == 63);
      checks++;
      if ({got[i].d, got[i].sof, got[i].eob} !== {exp_q[i], es, ee}) begin
        failures++;
        $display("FAIL ovf_seq[%0d] got=%h/%b/%b expected=%h/%b/%b", i, got[i].d, got[i].sof, got[i].eob, exp_q[i], es, ee);
      end
    end
    checks++;
    if (ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky got=%b expected=1", ovf);
    end
  endtask

  task automatic test_negative();
    logic [11:0] blk [64];
    do_reset();
    out_en = 1'b1;
    for (int i = 0; i < 64; i++) blk[i] = 12'($urandom);
    blk[0]  = 12'h800;
    blk[63] = 12'hFFF;
    push_expected(blk);
    for (int i = 0; i < 64; i++) drive_coef(blk[i]);
    stop_in();
    wait_outputs(64);
    checks++;
    if (got.size() != 64) begin
      failures++;
      $display("FAIL neg_count got=%0d expected=64", got.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i].d !== exp_q[i]) begin
        failures++;
        $display("FAIL neg_seq[%0d] got=%h expected=%h", i, got[i].d, exp_q[i]);
      end
    end
    if (got.size() == 64) begin
      checks++;
      if ({got[0].d, got[63].d} !== {12'h800, 12'hFFF}) begin
        failures++;
        $display("FAIL neg_endpoints got=%h/%h expected=800/fff", got[0].d, got[63].d);
      end
    end
  endtask

  task automatic test_random_stall();
    logic [11:0] data [$];
    int k = 0;
    int budget = 0;
    do_reset();
    for (int b = 0; b < 3; b++) begin
      logic [11:0] blk [64];
      for (int i = 0; i < 64; i++) begin
        blk[i] = 12'($urandom);
        data.push_back(blk[i]);
      end
      push_expected(blk);
    end
    while (k < 192 && budget < 5000) begin
      @(posedge CLK);
      #1;
      budget++;
      out_en = ($urandom_range(7) != 0);
      if ($urandom_range(2) == 0) begin
        rdy_in = 1'b1;
        dct_in = data[k];
        k++;
      end else begin
        rdy_in = 1'b0;
      end
    end
    @(posedge CLK);
    #1;
    rdy_in = 1'b0;
    budget = 0;
    while (got.size() < 192 && budget < 3000) begin
      @(posedge CLK);
      #1;
      budget++;
      out_en = ($urandom_range(7) != 0);
    end
    out_en = 1'b1;
    repeat (10) @(posedge CLK);
    checks++;
    if (got.size() != 192) begin
      failures++;
      $display("FAIL rand_count got=%0d expected=192", got.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      logic es = (i % 64 == 0);
      logic ee = (i % 64 == 63);
      checks++;
      if ({got[i].d, got[i].sof, got[i].eob} !== {exp_q[i], es, ee}) begin
        failures++;
        $display("FAIL rand_seq[%0d] got=%h/%b/%b expected=%h/%b/%b", i, got[i].d, got[i].sof, got[i].eob, exp_q[i], es, ee);
      end
    end
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL rand_ovf got=%b expected=0", ovf);
    end
  endtask

  task automatic test_reset_mid_block();
    logic [11:0] blk [64];
    do_reset();
    out_en = 1'b1;
    for (int i = 0; i < 64; i++) blk[i] = 12'($urandom);
    for (int i = 0; i < 64; i++) drive_coef(blk[i]);
    for (int i = 0; i < 30; i++) drive_coef(12'($urandom));
    @(posedge CLK);
    #1;
    rdy_in = 1'b0;
    RST = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      checks++;
      if ({zz_out, zz_valid, zz_sof, zz_eob, ovf} !== 16'h0) begin
        failures++;
        $display("FAIL midreset_outputs got=%h expected=0000", {zz_out, zz_valid, zz_sof, zz_eob, ovf});
      end
    end
    @(posedge CLK);
    #1;
    RST = 1'b1;
    got.delete();
    exp_q.delete();
    for (int i = 0; i < 64; i++) blk[i] = 12'(200 + i);
    push_expected(blk);
    for (int i = 0; i < 64; i++) drive_coef(blk[i]);
    stop_in();
    wait_outputs(64);
    checks++;
    if (got.size() != 64) begin
      failures++;
      $display("FAIL midreset_count got=%0d expected=64", got.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      logic es = (i % 64 == 0);
      logic ee = (i % 64 == 63);
      checks++;
      if ({got[i].d, got[i].sof, got[i].eob} !== {exp_q[i], es, ee}) begin
        failures++;
        $display("FAIL midreset_seq[%0d] got=%h/%b/%b expected=%h/%b/%b", i, got[i].d, got[i].sof, got[i].eob, exp_q[i], es, ee);
      end
    end
  endtask

  initial begin
    build_zigzag();
    test_reset();
    test_single_block();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_negative();
    test_random_stall();
    test_reset_mid_block();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
